// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the N-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int MAX_PORTS = 8;
    localparam int MAX_BW    = 64;

    function automatic logic [MAX_BW-1:0] be_all(input int dw);
        logic [MAX_BW-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BW; i++) begin
            if (i < dw / 8) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_arb_np_rr_pick.sv
// Round-robin search over secondary ports, starting just above rr_ptr.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int PORTS = 3,
    parameter int GW    = $clog2(PORTS)
) (
    input  logic [PORTS-1:1] pend_i,
    input  logic [GW-1:0]    rr_ptr_i,
    output logic             found_o,
    output logic [GW-1:0]    idx_o
);

    int c;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        c       = 0;
        for (int k = 1; k < PORTS; k++) begin
            c = int'(rr_ptr_i) + k;
            // wrap stays inside 1..PORTS-1, port 0 is never a candidate
            if (c >= PORTS) c = c - (PORTS - 1);
            if (!found_o && pend_i[c]) begin
                found_o = 1'b1;
                idx_o   = GW'(c);
            end
        end
    end

endmodule

// File: rtl/mem_arb_np.sv
// N-port req/ack toggle arbiter onto one single-ported memory,
// port 0 has priority and may preempt, others share round-robin.
module mem_arb_np
    import mem_arb_pkg::*;
#(
    parameter int PORTS   = 3,
    parameter int AW      = 21,
    parameter int DW      = 16,
    parameter int DLY_W   = 3,
    parameter int PREEMPT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DLY_W-1:0]           mem_delay,
    input  logic [DW-1:0]              mem_do,
    output logic [DW-1:0]              mem_di,
    output logic [AW:1]                mem_addr,
    output logic [DW/8-1:0]            mem_be,
    output logic                       mem_oe,
    output logic                       mem_we,
    input  logic [PORTS-1:0]           p_req,
    output logic [PORTS-1:0]           p_ack,
    input  logic [PORTS-1:0]           p_we,
    input  logic [PORTS*DW/8-1:0]      p_be,
    input  logic [PORTS*AW-1:0]        p_addr,
    input  logic [PORTS*DW-1:0]        p_di,
    output logic [PORTS*DW-1:0]        p_do,
    output logic                       busy,
    output logic [$clog2(PORTS)-1:0]   grant
);

    localparam int BW = DW / 8;
    localparam int GW = $clog2(PORTS);
    localparam logic [MAX_BW-1:0] BE_FULL = be_all(DW);

    state_t              state_q, state_d;
    logic [DLY_W-1:0]    cnt_q, cnt_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       rr_q, rr_d;
    logic [AW:1]         addr_q, addr_d;
    logic [DW-1:0]       di_q, di_d;
    logic [BW-1:0]       be_q, be_d;
    logic                oe_q, oe_d;
    logic                we_q, we_d;
    logic [PORTS-1:0]    ack_q, ack_d;
    logic [PORTS*DW-1:0] do_q, do_d;

    logic [PORTS-1:0]    pend;
    logic                found;
    logic [GW-1:0]       rr_idx;
    logic [GW-1:0]       sel;
    logic                go;
    logic                preempt;

    assign pend = p_req ^ ack_q;

    rr_pick #(.PORTS(PORTS), .GW(GW)) u_rr (
        .pend_i   (pend[PORTS-1:1]),
        .rr_ptr_i (rr_q),
        .found_o  (found),
        .idx_o    (rr_idx)
    );

    // abort only with at least two wait cycles left, else just finish
    assign preempt = (PREEMPT != 0) && (grant_q != '0) && pend[0]
                     && (cnt_q > DLY_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        di_d    = di_q;
        be_d    = be_q;
        oe_d    = oe_q;
        we_d    = we_q;
        ack_d   = ack_q;
        do_d    = do_q;
        sel     = '0;
        go      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend[0]) begin
                    go  = 1'b1;
                    sel = '0;
                end else if (found) begin
                    go  = 1'b1;
                    sel = rr_idx;
                end
                if (go) begin
                    addr_d  = p_addr[int'(sel)*AW +: AW];
                    di_d    = p_di[int'(sel)*DW +: DW];
                    be_d    = p_we[sel] ? p_be[int'(sel)*BW +: BW]
                                        : BE_FULL[BW-1:0];
                    oe_d    = !p_we[sel];
                    we_d    = p_we[sel];
                    cnt_d   = mem_delay;
                    grant_d = sel;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (preempt) begin
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DLY_W'(1);
                end else begin
                    if (!we_q) do_d[int'(grant_q)*DW +: DW] = mem_do;
                    ack_d[grant_q] = p_req[grant_q];
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    if (grant_q != '0) rr_d = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            rr_q    <= '0;
            addr_q  <= '0;
            di_q    <= '0;
            be_q    <= '0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            di_q    <= di_d;
            be_q    <= be_d;
            oe_q    <= oe_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            do_q    <= do_d;
        end
    end

    assign mem_addr = addr_q;
    assign mem_di   = di_q;
    assign mem_be   = be_q;
    assign mem_oe   = oe_q;
    assign mem_we   = we_q;
    assign p_ack    = ack_q;
    assign p_do     = do_q;
    assign grant    = grant_q;
    assign busy     = (state_q == ST_ACCESS);

endmodule
